// File: rtl/encoder_pkg.sv
// Frame layout shared by the UART packet encoder and its far-end decoder.
// Control byte sits directly above the two pattern fields.
package encoder_pkg;

  localparam int unsigned CtrlW = 8;

  typedef struct packed {
    logic [3:0] sel_out;
    logic       rsvd;
    logic       mode;
    logic       stop;
    logic       start;
  } ctrl_t;

  function automatic int unsigned freq_index(input int unsigned data_bit);
    return data_bit;
  endfunction

  function automatic int unsigned ctrl_index(input int unsigned data_bit);
    return 2 * data_bit;
  endfunction

  function automatic int unsigned pack_bit(input int unsigned pack_num);
    return 8 * pack_num;
  endfunction

endpackage

// File: rtl/encoder_if.sv
// Pattern/control inputs and uart_tx handshake of the packet encoder.
interface encoder_if #(
  parameter int unsigned DATA_BIT = 32
);
  logic [DATA_BIT-1:0] i_output_pattern;
  logic [DATA_BIT-1:0] i_freq_pattern;
  logic                i_start;
  logic                i_stop;
  logic                i_mode;
  logic [3:0]          i_sel_out;
  logic                i_load_tick;
  logic                i_tx_done_tick;
  logic [7:0]          o_tx_data;
  logic                o_tx_start_tick;
  logic                o_busy;
  logic                o_done_tick;

  modport master (
    output i_output_pattern, i_freq_pattern, i_start, i_stop, i_mode, i_sel_out,
    output i_load_tick, i_tx_done_tick,
    input  o_tx_data, o_tx_start_tick, o_busy, o_done_tick
  );

  modport slave (
    input  i_output_pattern, i_freq_pattern, i_start, i_stop, i_mode, i_sel_out,
    input  i_load_tick, i_tx_done_tick,
    output o_tx_data, o_tx_start_tick, o_busy, o_done_tick
  );
endinterface

// File: rtl/encoder.sv
// Packs one pattern/control set into a PACK_NUM-byte frame and feeds uart_tx LSB byte first.
// Single FSMD: buffer shifts right one byte per completed transmission.
module encoder
  import encoder_pkg::*;
#(
  parameter int unsigned DATA_BIT = 32,
  parameter int unsigned PACK_NUM = 9
) (
  input logic      clk,
  input logic      rst,
  encoder_if.slave bus
);

  localparam int unsigned PackBit   = pack_bit(PACK_NUM);
  localparam int unsigned FreqIndex = freq_index(DATA_BIT);
  localparam int unsigned CtrlIndex = ctrl_index(DATA_BIT);
  localparam int unsigned CntW      = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PACK_NUM - 1);

  if (PackBit < CtrlIndex + CtrlW) begin : g_size_check
    $error("encoder: PACK_NUM too small to hold both patterns and the control byte");
  end

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e              state_q;
  logic [PackBit-1:0]  buf_q;
  logic [CntW-1:0]     cnt_q;
  logic                start_q;
  logic                done_q;
  logic                busy_q;
  logic [PackBit-1:0]  frame;
  ctrl_t               ctrl;

  always_comb begin
    ctrl         = '0;
    ctrl.start   = bus.i_start;
    ctrl.stop    = bus.i_stop;
    ctrl.mode    = bus.i_mode;
    ctrl.sel_out = bus.i_sel_out;
    frame                          = '0;
    frame[DATA_BIT-1:0]            = bus.i_output_pattern;
    frame[FreqIndex +: DATA_BIT]   = bus.i_freq_pattern;
    frame[CtrlIndex +: CtrlW]      = ctrl;
  end

  // Strobe and busy flags are set on the transition so they mirror the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_load_tick) begin
            buf_q   <= frame;
            cnt_q   <= '0;
            state_q <= StSend;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StSend: state_q <= StWait;
        StWait: begin
          if (bus.i_tx_done_tick) begin
            if (cnt_q == LastCnt) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              buf_q   <= buf_q >> 8;
              cnt_q   <= cnt_q + 1'b1;
              state_q <= StSend;
              start_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_tx_data       = buf_q[7:0];
  assign bus.o_tx_start_tick = start_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_done_tick     = done_q;

endmodule
